iob_sp_ram_loader: RTL
======================

IOB_SP_RAM_LOADER -- requirements
Module: iob_sp_ram_loader

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, meaning the word width.
REQ-002 The block SHALL have parameter ADDR_W, default 10, meaning the RAM address width; RAM depth is 2**ADDR_W.
REQ-003 The block SHALL have port clk  input  1  system clock; all state updates on the rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 The block SHALL have port start  input  1  one-cycle load request.
REQ-006 The block SHALL have port base_addr  input  ADDR_W  first RAM address, sampled with start.
REQ-007 The block SHALL have port len  input  ADDR_W+1  word count, 0..2**ADDR_W, sampled with start.
REQ-008 The block SHALL have port abort  input  1  terminate the current load.
REQ-009 The block SHALL have port in_valid  input  1  stream word available.
REQ-010 The block SHALL have port in_data  input  DATA_W  stream word.
REQ-011 The block SHALL have port in_ready  output  1  block accepts a word this cycle.
REQ-012 The block SHALL have port mem_en  output  1  RAM enable.
REQ-013 The block SHALL have port mem_we  output  1  RAM write enable.
REQ-014 The block SHALL have port mem_addr  output  ADDR_W  RAM address.
REQ-015 The block SHALL have port mem_wdata  output  DATA_W  RAM write data.
REQ-016 The block SHALL have port busy  output  1  load in progress.
REQ-017 The block SHALL have port done  output  1  one-cycle completion pulse.
REQ-018 The block SHALL have port wcount  output  ADDR_W+1  words accepted in the current/last load.

Function
REQ-019 The FSM SHALL have states IDLE, LOAD, FINISH.
REQ-020 In IDLE, start=1 with len>0 SHALL latch base_addr and len, clear wcount, and enter LOAD next cycle.
REQ-021 In IDLE, start=1 with len=0 SHALL assert done for exactly the next cycle, clear wcount, and remain in IDLE with no RAM access.
REQ-022 in_ready SHALL equal 1 only in LOAD (registered state, not dependent on in_valid).
REQ-023 A word SHALL be accepted on a cycle with in_valid=1 and in_ready=1; in_valid=0 cycles SHALL stall without side effects.
REQ-024 Each accepted word SHALL appear on the RAM port exactly one cycle later: mem_en=mem_we=1, mem_addr=current write address, mem_wdata=accepted in_data.
REQ-025 mem_en and mem_we SHALL be 0 in every cycle not following an acceptance.
REQ-026 The write address SHALL start at base_addr and increment by 1 per acceptance, wrapping from 2**ADDR_W-1 to 0.
REQ-027 wcount SHALL increment by 1 per acceptance and hold its value after the load until the next start.
REQ-028 The acceptance making wcount equal to len SHALL move the FSM to FINISH; in_ready SHALL be 0 in FINISH.
REQ-029 FINISH SHALL last one cycle, coincide with the final RAM write, assert done, then return to IDLE.
REQ-030 busy SHALL be 1 in LOAD and FINISH, 0 in IDLE.
REQ-031 start SHALL be ignored while busy=1.
REQ-032 abort=1 in LOAD SHALL return the FSM to IDLE next cycle without done; a word accepted in that same cycle SHALL NOT be accepted (abort masks in_ready-qualified acceptance) and no further RAM writes SHALL occur except one already pending from the previous cycle.
REQ-033 abort in IDLE or FINISH SHALL have no effect.
REQ-034 Throughput SHALL be one word per cycle with in_valid held high; a len=N load SHALL take N+1 cycles from first acceptance to done.

Reset
REQ-035 rst=1 SHALL force, on the next edge, state IDLE, in_ready=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, wcount=0.
REQ-036 rst SHALL take priority over start and abort, and reset mid-load SHALL discard any pending RAM write.

Verification
REQ-037 ADDR_W=4, base_addr=2, len=3, in_valid held high with data A1,B2,C3 -> writes (2,A1),(3,B2),(4,C3) on consecutive cycles, done one cycle with last write, wcount=3.
REQ-038 base_addr=14, len=4, data 10..13 -> writes to addresses 14,15,0,1; no write to any other address.
REQ-039 len=5, in_valid toggling 1,0,1,0,... -> exactly 5 writes, mem_we=0 in stall-following cycles, done after fifth write.
REQ-040 len=0 start -> done=1 next cycle, busy=0 throughout, mem_en never asserted.
REQ-041 len=8, abort asserted after 3 acceptances -> exactly 3 writes, no done, wcount=3, busy=0 next cycle; a start during the load ignored.
REQ-042 rst asserted during LOAD after 2 acceptances -> next cycle all outputs at REQ-035 values, no further writes, new start works normally.

Source files
------------

// File: rtl/iob_sp_ram_loader.sv
`default_nettype none
// ============================================================================
// Module   : iob_sp_ram_loader
// Purpose  : Loads a valid/ready word stream into a single-port RAM, starting
//            at a requested base address for a requested word count.
//            Each accepted word is written to the RAM one cycle later.
// Revision : 1.0  initial release
// ============================================================================
module iob_sp_ram_loader #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W:0]   len,
   input  logic              abort,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W:0]   wcount
);

   localparam logic [1:0] c_idle   = 2'd0;
   localparam logic [1:0] c_load   = 2'd1;
   localparam logic [1:0] c_finish = 2'd2;

   localparam logic [ADDR_W-1:0] c_addr_one = {{(ADDR_W-1){1'b0}}, 1'b1};
   localparam logic [ADDR_W:0]   c_cnt_one  = {{ADDR_W{1'b0}}, 1'b1};

   logic [1:0]        state_q,     state_d;
   logic [ADDR_W-1:0] addr_q,      addr_d;
   logic [ADDR_W:0]   len_q,       len_d;
   logic [ADDR_W:0]   wcount_q,    wcount_d;
   logic              mem_en_q,    mem_en_d;
   logic              mem_we_q,    mem_we_d;
   logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic              done_q,      done_d;

   logic              w_accept;
   logic [ADDR_W:0]   w_wcount_inc;

   // Abort masks acceptance in the same cycle, so an aborted word is never written.
   assign w_accept     = (state_q == c_load) && in_valid && !abort;
   assign w_wcount_inc = wcount_q + c_cnt_one;

   // Next-state and RAM-port decode; the RAM port is registered one cycle behind acceptance.
   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      len_d       = len_q;
      wcount_d    = wcount_q;
      mem_en_d    = 1'b0;
      mem_we_d    = 1'b0;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      done_d      = 1'b0;
      case (state_q)
         c_idle: begin
            if (start) begin
               wcount_d = '0;
               if (len == '0) begin
                  // Empty load completes immediately without touching the RAM.
                  done_d = 1'b1;
               end else begin
                  addr_d  = base_addr;
                  len_d   = len;
                  state_d = c_load;
               end
            end
         end
         c_load: begin
            if (abort) begin
               state_d = c_idle;
            end else if (w_accept) begin
               mem_en_d    = 1'b1;
               mem_we_d    = 1'b1;
               mem_addr_d  = addr_q;
               mem_wdata_d = in_data;
               addr_d      = addr_q + c_addr_one;
               wcount_d    = w_wcount_inc;
               if (w_wcount_inc == len_q) begin
                  // FINISH coincides with the final write, so done rises with it.
                  state_d = c_finish;
                  done_d  = 1'b1;
               end
            end
         end
         c_finish: begin
            state_d = c_idle;
         end
         default: begin
            state_d = c_idle;
         end
      endcase
   end

   // State register; reset also discards any write pending on the RAM port.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= c_idle;
         addr_q      <= '0;
         len_q       <= '0;
         wcount_q    <= '0;
         mem_en_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         len_q       <= len_d;
         wcount_q    <= wcount_d;
         mem_en_q    <= mem_en_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         done_q      <= done_d;
      end
   end

   assign in_ready  = (state_q == c_load);
   assign busy      = (state_q != c_idle);
   assign mem_en    = mem_en_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign done      = done_q;
   assign wcount    = wcount_q;

endmodule
`default_nettype wire
